transpose_stream: RTL and testbench
===================================

# transpose_stream

Streaming 8x8 transpose buffer with valid/ready handshakes on both sides. It sits between the row pass and the column pass of the 2-D DCT in the JPEG accelerator. It accepts one 8-element row per handshake and, once a full block is stored, returns the block one 8-element column per handshake. It owns all sequencing internally, so neither neighbouring stage drives write or read strobes.

## Interface
- `DW`, default 12: width of one coefficient element; data buses are 8*DW bits.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `in_valid`  in  1: upstream presents a row on `in_data`.
- `in_ready`  out  1: block can accept a row this cycle.
- `in_data`  in  8*DW: row; element c at bits [DW*(8-c)-1 : DW*(7-c)], so element 0 is in the MSBs.
- `out_valid`  out  1: a column is presented on `out_data`.
- `out_ready`  in  1: downstream accepts the column.
- `out_data`  out  8*DW: column c; the element from row r is at bits [DW*(r+1)-1 : DW*r], so row 0 is in the LSBs.
- `out_last`  out  1: high together with `out_valid` when column 7 of a block is presented.
- `busy`  out  1: at least one row of any bank is stored and not yet fully drained.

## Operation
- Storage: per bank, 8 rows x 8*DW bits, plus a 3-bit write row counter `wcnt` and a 3-bit read column counter `rcnt`. Rows are written at index `wcnt`. `out_data` is a combinational mux selecting element `rcnt` of every stored row of the read bank.
- Input transfer occurs on an edge where `in_valid && in_ready`. The row is stored and `wcnt` increments. On `wcnt == 7` the transfer marks the write bank full, and `wcnt` wraps to 0.
- Output transfer occurs on an edge where `out_valid && out_ready`. `rcnt` increments. On `rcnt == 7` the transfer marks the read bank empty, and `rcnt` wraps to 0.
- Per-bank state machine:
  - EMPTY: a bank is EMPTY until its 8th row is written.
  - FULL: then FULL until its 8th column is read.
  - FULL to EMPTY: the bank returns to EMPTY at that 8th read.
- `in_ready` = write bank not FULL. `out_valid` = read bank FULL. `out_last` = `out_valid && rcnt == 7`.
- Simultaneous input and output transfer in the same cycle on different banks is legal and both take effect. On the same bank it cannot occur, since `in_ready` and `out_valid` are mutually exclusive per bank.
- `in_valid` may deassert mid-block; gaps are allowed, and `wcnt` holds.
- `out_ready` may deassert mid-block; `rcnt` and `out_data` hold stable.
- Reset, asynchronous and possible at any point including mid-fill or mid-drain:
  - all banks EMPTY, counters 0, bank pointers 0;
  - storage cleared to 0;
  - partial blocks are discarded.
- Reset output values: `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0, `out_data`=0.

## Timing
- Latency: `out_valid` rises on the edge that accepts row 7, so it is visible the cycle after that handshake. The first column is available immediately.
- With handshakes continuously asserted, single bank: 8 fill cycles plus 8 drain cycles, giving 16 cycles per block.
- Double bank: sustained 8 cycles per block after an initial 8-cycle fill.
- `in_ready` and `out_valid` are registered-state functions only. There is no combinational path from `in_valid` or `out_ready`.
- `out_data` changes only on an output transfer edge or when a bank becomes FULL.

## Configuration
- `TRANSPOSE_PINGPONG_EN` defined: two banks.
  - Write pointer toggles when a bank becomes FULL; read pointer toggles when a bank becomes EMPTY.
  - The next block is filled while the previous one drains.
  - `in_ready` drops only when both banks are FULL.
- Not defined: one bank.
  - `in_ready` is 0 for the whole drain phase.
  - `out_valid` is 0 for the whole fill phase.

## Test plan
- Single block, element(r,c)=16*r+c, handshakes held high -> column 0 word holds 0x000,0x010,…,0x070 (row 0 in LSBs). `out_last` is high only on column 7. `busy` returns to 0 the cycle after.
- Same block with `out_ready` low for 3 cycles while column 2 is presented -> `out_data` holds the column-2 value and `rcnt` holds. Columns 3..7 follow correctly.
- Without macro, `in_valid` held high throughout -> `in_ready`=0 for exactly 8 cycles after row 7. The 9th row is accepted on the cycle of the last column transfer + 1.
- With macro, 16 rows back-to-back, `out_ready` high -> `in_ready` never drops. The columns of block 1 start the cycle after row 7. Block 2 columns follow block 1 with no gap.
- With macro, `out_ready` low throughout, 17 rows offered -> `in_ready` falls after row 15 and the 17th row waits.
- `rst` pulsed mid-drain (after column 3) -> outputs immediately: `out_valid`=0, `in_ready`=1, `busy`=0. A fresh block then transposes correctly.

Source files
------------

// File: rtl/transpose_stream.sv
// transpose_stream: streaming 8x8 transpose buffer for the JPEG 2-D DCT.
// Accepts one 8-element row per input handshake. Once a block is complete,
// it returns that block one 8-element column per output handshake.
//
// Ports:
//   clk, rst    - clock; asynchronous active-high reset
//   in_valid    - upstream row valid
//   in_ready    - write bank can take a row (registered state only)
//   in_data     - row, element c at [DW*(8-c)-1 : DW*(7-c)] (element 0 in MSBs)
//   out_valid   - read bank holds a complete block (registered state only)
//   out_ready   - downstream accepts the column
//   out_data    - column, element of row r at [DW*(r+1)-1 : DW*r] (row 0 in LSBs)
//   out_last    - column 7 of a block is presented
//   busy        - some row is stored and not yet fully drained
//
// Build option: define TRANSPOSE_PINGPONG_EN for two banks, so the next block
// fills while the previous one drains. Without it there is a single bank.
module transpose_stream #(
  parameter int unsigned DW = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*DW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*DW-1:0] out_data,
  output logic            out_last,
  output logic            busy
);

`ifdef TRANSPOSE_PINGPONG_EN
  localparam int unsigned NB = 2;
`else
  localparam int unsigned NB = 1;
`endif

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  typedef logic [8*DW-1:0] row_t;

  row_t        mem_q   [NB][8];
  row_t        mem_d   [NB][8];
  bank_state_e bank_q  [NB];
  bank_state_e bank_d  [NB];
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [2:0]  rcnt_q, rcnt_d;

  logic        in_fire;
  logic        out_fire;
  logic [2:0]  elem_sel;

  // Outputs depend only on registered state. Bank selection is done by
  // comparing against the pointer so the single-bank build needs no index.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (wcnt_q != 3'd0);
    out_data  = '0;
    elem_sel  = 3'd7 - rcnt_q;
    for (int unsigned b = 0; b < NB; b++) begin
      if (1'(b) == wptr_q && bank_q[b] == BANK_EMPTY) begin
        in_ready = 1'b1;
      end
      if (1'(b) == rptr_q && bank_q[b] == BANK_FULL) begin
        out_valid = 1'b1;
        for (int unsigned r = 0; r < 8; r++) begin
          out_data[DW*r +: DW] = mem_q[b][r][DW*elem_sel +: DW];
        end
      end
      if (bank_q[b] == BANK_FULL) begin
        busy = 1'b1;
      end
    end
    out_last = out_valid && (rcnt_q == 3'd7);
  end

  always_comb begin
    mem_d    = mem_q;
    bank_d   = bank_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    wcnt_d   = wcnt_q;
    rcnt_d   = rcnt_q;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;

    for (int unsigned b = 0; b < NB; b++) begin
      if (in_fire && 1'(b) == wptr_q) begin
        mem_d[b][wcnt_q] = in_data;
        if (wcnt_q == 3'd7) begin
          bank_d[b] = BANK_FULL;
        end
      end
      if (out_fire && 1'(b) == rptr_q && rcnt_q == 3'd7) begin
        bank_d[b] = BANK_EMPTY;
      end
    end

    if (in_fire) begin
      wcnt_d = wcnt_q + 3'd1;
`ifdef TRANSPOSE_PINGPONG_EN
      if (wcnt_q == 3'd7) begin
        wptr_d = ~wptr_q;
      end
`endif
    end

    if (out_fire) begin
      rcnt_d = rcnt_q + 3'd1;
`ifdef TRANSPOSE_PINGPONG_EN
      if (rcnt_q == 3'd7) begin
        rptr_d = ~rptr_q;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < NB; b++) begin
        bank_q[b] <= BANK_EMPTY;
        for (int unsigned r = 0; r < 8; r++) begin
          mem_q[b][r] <= '0;
        end
      end
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      mem_q  <= mem_d;
      bank_q <= bank_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
    end
  end

endmodule

// File: tb/tb_transpose_stream.sv
// Directed bench for transpose_stream: table-driven single-block transpose
// with an output stall, plus hand-written back-pressure and reset sequences.
module tb_transpose_stream;

  localparam int unsigned DW = 12;
  localparam int unsigned W  = 8 * DW;
`ifdef TRANSPOSE_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  transpose_stream #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         e_ir;
    logic         e_ov;
    logic         e_ol;
    logic         e_busy;
    logic [W-1:0] e_od;
  } vec_t;

  vec_t tbl[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  function automatic logic [W-1:0] row_word(int unsigned base, int unsigned r);
    logic [W-1:0] w;
    w = '0;
    for (int unsigned c = 0; c < 8; c++) w[DW*(7-c) +: DW] = DW'(base + 16*r + c);
    return w;
  endfunction

  function automatic logic [W-1:0] col_word(int unsigned base, int unsigned c);
    logic [W-1:0] w;
    w = '0;
    for (int unsigned r = 0; r < 8; r++) w[DW*r +: DW] = DW'(base + 16*r + c);
    return w;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reset asserted away from the clock edge; returns aligned to posedge+1.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input logic [W-1:0] w);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; t < 50 && !done; t++) begin
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("push_row_timeout", W'(1'b0), W'(1'b1));
  endtask

  task automatic pop_col(input logic [W-1:0] exp, input logic exp_last);
    bit done = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      if (out_valid) begin
        check("pop_data", out_data, exp);
        check("pop_last", W'(out_last), W'(exp_last));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    if (!done) check("pop_col_timeout", W'(1'b0), W'(1'b1));
  endtask

  int acc, a7, lastc, acc9, zeros, ocol, first_out, gaps, drops;
  bit seen_drop;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Reset state
    check("rst_in_ready", W'(in_ready), W'(1'b1));
    check("rst_out_valid", W'(out_valid), W'(1'b0));
    check("rst_out_last", W'(out_last), W'(1'b0));
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_out_data", out_data, '0);

    // Table: fill one block, drain it with a 3-cycle stall on column 2
    for (int unsigned k = 0; k < 8; k++)
      tbl.push_back('{1'b1, row_word(0, k), 1'b1, 1'b1, 1'b0, 1'b0, (k > 0), '0});
    for (int unsigned c = 0; c < 8; c++) begin
      if (c == 2)
        for (int s = 0; s < 3; s++)
          tbl.push_back('{1'b0, '0, 1'b0, PP, 1'b1, 1'b0, 1'b1, col_word(0, c)});
      tbl.push_back('{1'b0, '0, 1'b1, PP, 1'b1, (c == 7), 1'b1, col_word(0, c)});
    end
    tbl.push_back('{1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0});

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].id;
      out_ready = tbl[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), W'(in_ready), W'(tbl[i].e_ir));
      check($sformatf("v%0d_out_valid", i), W'(out_valid), W'(tbl[i].e_ov));
      check($sformatf("v%0d_out_last", i), W'(out_last), W'(tbl[i].e_ol));
      check($sformatf("v%0d_busy", i), W'(busy), W'(tbl[i].e_busy));
      check($sformatf("v%0d_out_data", i), out_data, tbl[i].e_od);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset pulsed mid-drain after column 3, then a fresh block
    do_reset();
    for (int unsigned r = 0; r < 8; r++) push_row(row_word(12'h200, r));
    for (int unsigned c = 0; c < 4; c++) pop_col(col_word(12'h200, c), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(1'b0));
    check("midrst_in_ready", W'(in_ready), W'(1'b1));
    check("midrst_busy", W'(busy), W'(1'b0));
    check("midrst_out_data", out_data, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int unsigned r = 0; r < 8; r++) push_row(row_word(12'h300, r));
    for (int unsigned c = 0; c < 8; c++) pop_col(col_word(12'h300, c), (c == 7));
    check("fresh_busy_after", W'(busy), W'(1'b0));

    do_reset();
    if (!PP) begin
      // Single bank: in_valid held high, 9 rows offered
      acc = 0; a7 = -1; lastc = -1; acc9 = -1; zeros = 0; ocol = 0;
      out_ready = 1'b1;
      for (int t = 0; t < 30; t++) begin
        in_valid = (acc < 9);
        in_data  = row_word(0, acc);
        if (out_valid) begin
          if (ocol < 8) check("sb_col_data", out_data, col_word(0, ocol));
          if (out_last) lastc = t;
          ocol++;
        end
        if (!in_ready && a7 >= 0 && acc == 8) zeros++;
        if (in_valid && in_ready) begin
          if (acc == 7) a7 = t;
          if (acc == 8) acc9 = t;
          acc++;
        end
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      check("sb_row7_cycle", W'(a7), W'(7));
      check("sb_ready_low_cycles", W'(zeros), W'(8));
      check("sb_row9_cycle", W'(acc9), W'(lastc + 1));
    end else begin
      // Two banks: 16 rows back-to-back, out_ready high
      acc = 0; a7 = -1; ocol = 0; first_out = -1; gaps = 0; drops = 0;
      out_ready = 1'b1;
      for (int t = 0; t < 40; t++) begin
        in_valid = (acc < 16);
        in_data  = row_word((acc < 8) ? 0 : 12'h400, acc % 8);
        if (in_valid && !in_ready) drops++;
        if (out_valid) begin
          if (ocol < 16) begin
            check("pp_col_data", out_data, col_word((ocol < 8) ? 0 : 12'h400, ocol % 8));
            check("pp_col_last", W'(out_last), W'((ocol % 8) == 7));
          end
          if (ocol == 0) first_out = t;
          ocol++;
        end else if (ocol > 0 && ocol < 16) begin
          gaps++;
        end
        if (in_valid && in_ready) begin
          if (acc == 7) a7 = t;
          acc++;
        end
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      check("pp_ready_drops", W'(drops), W'(0));
      check("pp_first_col", W'(first_out), W'(a7 + 1));
      check("pp_col_gaps", W'(gaps), W'(0));
      check("pp_col_count", W'(ocol), W'(16));

      // Two banks: out_ready low, 17 rows offered
      do_reset();
      acc = 0; seen_drop = 1'b0;
      for (int t = 0; t < 30; t++) begin
        in_valid = (acc < 17);
        in_data  = row_word((acc < 8) ? 0 : 12'h400, acc % 8);
        if (acc == 16 && !seen_drop) begin
          check("pp_ready_after_row15", W'(in_ready), W'(1'b0));
          seen_drop = 1'b1;
        end
        if (in_valid && in_ready) acc++;
        @(posedge clk);
        #1;
      end
      check("pp_rows_accepted", W'(acc), W'(16));
      check("pp_ready_held_low", W'(in_ready), W'(1'b0));
      check("pp_stalled_col0", out_data, col_word(0, 0));
      pop_col(col_word(0, 0), 1'b0);
      check("pp_ready_still_low", W'(in_ready), W'(1'b0));
      in_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
